// File: rtl/vga_timing_ctrl_if.sv
// Scan-timing bundle between vga_timing_ctrl (master) and the pixel/screen-memory logic (slave).
interface vga_timing_ctrl_if #(
    parameter int X_W = 10,
    parameter int Y_W = 10
);
    logic           run;
    logic           pixel_en;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           active;
    logic           hsync;
    logic           vsync;
    logic           line_start;
    logic           frame_start;
    logic           busy;

    modport master (
        input  run,
        output pixel_en, x, y, active, hsync, vsync, line_start, frame_start, busy
    );

    modport slave (
        output run,
        input  pixel_en, x, y, active, hsync, vsync, line_start, frame_start, busy
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA scan sequencer: pixel-enable divider, x/y scan counters, syncs and frame markers.
// Optional macro VGA_SYNC_DELAY_EN delays hsync/vsync/active by SYNC_DELAY pixel ticks.
module vga_timing_ctrl #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_POL   = 0,
    parameter int SYNC_DELAY = 2
) (
    input  logic              clock,
    input  logic              reset,
    vga_timing_ctrl_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int Y_W     = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    // Region bounds carry one spare bit so an end bound equal to the total cannot wrap.
    localparam logic [X_W:0]     X_ACT_END = (X_W + 1)'(H_ACTIVE);
    localparam logic [X_W:0]     X_HS_BEG  = (X_W + 1)'(H_ACTIVE + H_FP);
    localparam logic [X_W:0]     X_HS_END  = (X_W + 1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W:0]     Y_ACT_END = (Y_W + 1)'(V_ACTIVE);
    localparam logic [Y_W:0]     Y_VS_BEG  = (Y_W + 1)'(V_ACTIVE + V_FP);
    localparam logic [Y_W:0]     Y_VS_END  = (Y_W + 1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic             SYNC_ON   = (SYNC_POL != 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             act_q, act_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             pixel_en;
    logic             x_last;
    logic             y_last;
    logic             eof;

    assign pixel_en = (state_q != ST_IDLE) && (div_q == DIV_LAST);
    assign x_last   = (x_q == X_LAST);
    assign y_last   = (y_q == Y_LAST);
    assign eof      = pixel_en && x_last && y_last;

    // A stop request only takes effect on the final pixel of a frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (vif.run) state_d = ST_RUN;
            ST_RUN:   if (!vif.run) state_d = eof ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (vif.run)  state_d = ST_RUN;
                else if (eof) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        div_d = '0;
        x_d   = '0;
        y_d   = '0;
        if (state_q != ST_IDLE) begin
            div_d = pixel_en ? '0 : div_q + DIV_W'(1);
            x_d   = x_q;
            y_d   = y_q;
            if (pixel_en) begin
                if (x_last) begin
                    x_d = '0;
                    y_d = y_last ? '0 : y_q + Y_W'(1);
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
        end
    end

    // Region flags are derived from the next counts so they line up with x/y.
    always_comb begin
        act_d = 1'b0;
        hs_d  = ~SYNC_ON;
        vs_d  = ~SYNC_ON;
        if (state_d != ST_IDLE) begin
            act_d = ({1'b0, x_d} < X_ACT_END) && ({1'b0, y_d} < Y_ACT_END);
            if (({1'b0, x_d} >= X_HS_BEG) && ({1'b0, x_d} < X_HS_END)) hs_d = SYNC_ON;
            if (({1'b0, y_d} >= Y_VS_BEG) && ({1'b0, y_d} < Y_VS_END)) vs_d = SYNC_ON;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            act_q   <= 1'b0;
            hs_q    <= ~SYNC_ON;
            vs_q    <= ~SYNC_ON;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            act_q   <= act_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    localparam int SD = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;

    logic [SD-1:0] hs_pipe_q, hs_pipe_d;
    logic [SD-1:0] vs_pipe_q, vs_pipe_d;
    logic [SD-1:0] act_pipe_q, act_pipe_d;

    // Pipes step once per pixel and are flushed whenever the scan returns to idle.
    always_comb begin
        hs_pipe_d  = hs_pipe_q;
        vs_pipe_d  = vs_pipe_q;
        act_pipe_d = act_pipe_q;
        if (state_d == ST_IDLE) begin
            hs_pipe_d  = {SD{~SYNC_ON}};
            vs_pipe_d  = {SD{~SYNC_ON}};
            act_pipe_d = '0;
        end else if (pixel_en) begin
            hs_pipe_d     = hs_pipe_q << 1;
            hs_pipe_d[0]  = hs_q;
            vs_pipe_d     = vs_pipe_q << 1;
            vs_pipe_d[0]  = vs_q;
            act_pipe_d    = act_pipe_q << 1;
            act_pipe_d[0] = act_q;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hs_pipe_q  <= {SD{~SYNC_ON}};
            vs_pipe_q  <= {SD{~SYNC_ON}};
            act_pipe_q <= '0;
        end else begin
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            act_pipe_q <= act_pipe_d;
        end
    end

    assign vif.hsync  = hs_pipe_q[SD-1];
    assign vif.vsync  = vs_pipe_q[SD-1];
    assign vif.active = act_pipe_q[SD-1];
`else
    assign vif.hsync  = hs_q;
    assign vif.vsync  = vs_q;
    assign vif.active = act_q;
`endif

    assign vif.pixel_en    = pixel_en;
    assign vif.x           = x_q;
    assign vif.y           = y_q;
    assign vif.line_start  = pixel_en && (x_q == '0);
    assign vif.frame_start = pixel_en && (x_q == '0) && (y_q == '0);
    assign vif.busy        = (state_q != ST_IDLE);
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a reduced-geometry CLK_DIV=4 instance and a tiny CLK_DIV=1 instance.
module tb_vga_timing_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    // A: 16/2/3/3 x 10/2/2/2 -> 24 x 16 scan, hsync x=18..20, vsync y=12..13
    vga_timing_ctrl_if #(.X_W(5), .Y_W(4)) vif_a ();
    // B: 4/1/1/1 x 2/1/1/1 -> 7 x 5 scan, hsync x=5, vsync y=3
    vga_timing_ctrl_if #(.X_W(3), .Y_W(3)) vif_b ();

    vga_timing_ctrl #(
        .CLK_DIV(4), .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(2), .SYNC_POL(0), .SYNC_DELAY(2)
    ) dut_a (
        .clock(clk), .reset(rst_a), .vif(vif_a)
    );

    vga_timing_ctrl #(
        .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(0), .SYNC_DELAY(2)
    ) dut_b (
        .clock(clk), .reset(rst_b), .vif(vif_b)
    );

`ifdef VGA_SYNC_DELAY_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    typedef struct {
        logic run;
        int   ex;
        int   ey;
        logic ehs;
        logic evs;
        logic eact;
        logic els;
        logic efs;
    } vec_t;

    localparam int NV = 38;
    vec_t vecs[NV];

    // Undelayed per-column / per-row values for the 7x5 scan.
    logic col_hs  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic col_act [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic row_vs  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic row_act [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_a(input string tag);
        check({tag, "_x"},        vif_a.x, 0);
        check({tag, "_y"},        vif_a.y, 0);
        check({tag, "_pixel_en"}, vif_a.pixel_en, 0);
        check({tag, "_active"},   vif_a.active, 0);
        check({tag, "_busy"},     vif_a.busy, 0);
        check({tag, "_hsync"},    vif_a.hsync, 1);
        check({tag, "_vsync"},    vif_a.vsync, 1);
        check({tag, "_line_st"},  vif_a.line_start, 0);
        check({tag, "_frame_st"}, vif_a.frame_start, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int cnt, pe_cnt, act_cnt, hs_cnt, hs_first, vs_cnt, vs_ymin, vs_ymax, fs_cnt;
        logic prev_pe;
        int prev_x, prev_y;

        for (int n = 0; n < NV; n++) begin
            int m;
            vecs[n].run = 1'b1;
            vecs[n].ex  = n % 7;
            vecs[n].ey  = (n / 7) % 5;
            vecs[n].els = (n % 7) == 0;
            vecs[n].efs = (n % 35) == 0;
            m = n - DLY;
            if (m < 0) begin
                vecs[n].ehs  = 1'b1;
                vecs[n].evs  = 1'b1;
                vecs[n].eact = 1'b0;
            end else begin
                vecs[n].ehs  = col_hs[m % 7];
                vecs[n].evs  = row_vs[(m / 7) % 5];
                vecs[n].eact = col_act[m % 7] & row_act[(m / 7) % 5];
            end
        end

        // Reset held with run=1: everything stays at reset values.
        rst_a = 1'b1; vif_a.run = 1'b1;
        rst_b = 1'b1; vif_b.run = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_idle_a("reset");

        // First pixel_en four edges after reset release, at pixel (0,0).
        rst_a = 1'b0;
        cnt = 0;
        do begin
            tick();
            cnt++;
            if (cnt == 1) check("busy_rise", vif_a.busy, 1);
        end while (!vif_a.pixel_en && cnt < 20);
        check("first_pe_latency", cnt, 4);
        check("first_frame_start", vif_a.frame_start, 1);
        check("first_line_start", vif_a.line_start, 1);
        check("first_x", vif_a.x, 0);
        check("first_y", vif_a.y, 0);
        check("first_active", vif_a.active, 1);

        // One full frame of statistics.
        pe_cnt = 0; act_cnt = 0; hs_cnt = 0; hs_first = -1;
        vs_cnt = 0; vs_ymin = 99; vs_ymax = -1; fs_cnt = 0;
        for (int n = 0; n < 24 * 16 * 4; n++) begin
            if (vif_a.pixel_en) begin
                pe_cnt++;
                if (vif_a.active) act_cnt++;
                if (vif_a.frame_start) fs_cnt++;
                if (!vif_a.hsync) begin
                    hs_cnt++;
                    if (vif_a.y == 0 && hs_first < 0) hs_first = int'(vif_a.x);
                end
                if (!vif_a.vsync) begin
                    vs_cnt++;
                    if (int'(vif_a.y) < vs_ymin) vs_ymin = int'(vif_a.y);
                    if (int'(vif_a.y) > vs_ymax) vs_ymax = int'(vif_a.y);
                end
            end
            tick();
        end
        check("frame_pe_count", pe_cnt, 384);
        check("frame_active_count", act_cnt, 160);
        check("frame_hsync_pixels", hs_cnt, 48);
        check("frame_hsync_first_x", hs_first, 18);
        check("frame_vsync_pixels", vs_cnt, 48);
        check("frame_vsync_first_line", vs_ymin, 12);
        check("frame_vsync_last_line", vs_ymax, 13);
        check("frame_fs_count", fs_cnt, 1);
        check("wrap_frame_start", vif_a.frame_start, 1);
        check("wrap_x", vif_a.x, 0);
        check("wrap_y", vif_a.y, 0);

        // run 1->0->1 mid-frame: frame spacing unchanged.
        cnt = 0;
        do begin
            if (cnt == 100) vif_a.run = 1'b0;
            if (cnt == 160) vif_a.run = 1'b1;
            tick();
            cnt++;
            if (cnt == 130) check("drain_busy", vif_a.busy, 1);
        end while (!vif_a.frame_start && cnt < 2000);
        check("resume_fs_spacing", cnt, 1536);

        // Clean stop requested mid-frame at (5,8).
        cnt = 0;
        while (!(vif_a.x == 5 && vif_a.y == 8) && cnt < 2000) begin
            tick();
            cnt++;
        end
        check("stop_reach_point", cnt < 2000, 1);
        vif_a.run = 1'b0;
        cnt = 0;
        prev_pe = 1'b0; prev_x = -1; prev_y = -1;
        do begin
            prev_pe = vif_a.pixel_en;
            prev_x  = int'(vif_a.x);
            prev_y  = int'(vif_a.y);
            tick();
            cnt++;
        end while (vif_a.busy && cnt < 3000);
        check("stop_busy_fall", vif_a.busy, 0);
        check("stop_last_pe", prev_pe, 1);
        check("stop_last_x", prev_x, 23);
        check("stop_last_y", prev_y, 15);
        check_idle_a("stop_idle");
        pe_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (vif_a.pixel_en) pe_cnt++;
        end
        check("stop_no_more_pe", pe_cnt, 0);

        // Mid-frame reset inside the sync region (x=19, y=12).
        vif_a.run = 1'b1;
        cnt = 0;
        while (!(vif_a.x == 19 && vif_a.y == 12) && cnt < 3000) begin
            tick();
            cnt++;
        end
        check("mrst_pre_hsync", vif_a.hsync, 0);
        check("mrst_pre_vsync", vif_a.vsync, 0);
        rst_a = 1'b1;
        tick();
        check_idle_a("mid_reset");
        rst_a = 1'b0;
        vif_a.run = 1'b0;
        tick();
        check("mrst_stays_idle", vif_a.busy, 0);

        // Instance B: CLK_DIV=1 must still gate pixel_en in idle.
        tick();
        check("b_idle_pe", vif_b.pixel_en, 0);
        check("b_idle_busy", vif_b.busy, 0);
        check("b_idle_x", vif_b.x, 0);
        rst_b = 1'b0;
        vif_b.run = 1'b1;
        tick();
        for (int n = 0; n < NV; n++) begin
            vif_b.run = vecs[n].run;
            check($sformatf("b_pe[%0d]", n),     vif_b.pixel_en, 1);
            check($sformatf("b_x[%0d]", n),      vif_b.x, vecs[n].ex);
            check($sformatf("b_y[%0d]", n),      vif_b.y, vecs[n].ey);
            check($sformatf("b_hsync[%0d]", n),  vif_b.hsync, vecs[n].ehs);
            check($sformatf("b_vsync[%0d]", n),  vif_b.vsync, vecs[n].evs);
            check($sformatf("b_active[%0d]", n), vif_b.active, vecs[n].eact);
            check($sformatf("b_line_st[%0d]", n), vif_b.line_start, vecs[n].els);
            check($sformatf("b_frame_st[%0d]", n), vif_b.frame_start, vecs[n].efs);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
